// File: rtl/key_search_pkg.sv
// Shared types and default parameters for the key search controller.
// The optional KEY_SEARCH_PROGRESS_EN build adds a tried_count output to key_search_ctrl.
package key_search_pkg;

  localparam int KEY_W_DEF         = 24;
  localparam int STRIDE_DEF        = 1;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int SETTLE_CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FOUND     = 3'd4,
    ST_EXHAUSTED = 3'd5
  } state_t;

endpackage

// File: rtl/key_search_settle_cnt.sv
// Loadable down-counter that times how long the engine stays in reset for each key.
// done is high whenever the count has reached zero.
module key_search_settle_cnt
  import key_search_pkg::*;
#(
  parameter int W = SETTLE_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer: steps keys through an external engine, one reset/start per key.
// Define KEY_SEARCH_PROGRESS_EN to add the tried_count output.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int KEY_W         = KEY_W_DEF,
  parameter int STRIDE        = STRIDE_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  input  logic             abort,
  input  logic             eng_done,
  input  logic             eng_fail,
  output logic             eng_reset,
  output logic             eng_start,
  output logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [2:0]       state_dbg
`ifdef KEY_SEARCH_PROGRESS_EN
  ,
  output logic [KEY_W:0]   tried_count
`endif
);

  // Handshake: start is a one-cycle request honoured only outside LOAD/SETTLE/RUN;
  // eng_done/eng_fail are sampled only in RUN, and eng_start is held high for the whole RUN stay.

  state_t                  state, state_n;
  logic [KEY_W-1:0]        key_n, found_key_n;
  logic [KEY_W-1:0]        key_hi_q, key_hi_n;
  logic [KEY_W:0]          next_key;
  logic                    cnt_load, cnt_dec, cnt_done;
  logic [SETTLE_CNT_W-1:0] cnt_val;
  logic                    start_ok, run_exit;

  // Extra bit catches a wrap past the top of the key space.
  assign next_key  = {1'b0, key} + (KEY_W+1)'(STRIDE);
  assign state_dbg = state;

  // Counter enters SETTLE at SETTLE_CYCLES-1, so done rises on the last settle cycle.
  key_search_settle_cnt #(.W(SETTLE_CNT_W)) u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_CNT_W'(SETTLE_CYCLES - 1)),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_n     = state;
    key_n       = key;
    found_key_n = found_key;
    key_hi_n    = key_hi_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    start_ok    = 1'b0;
    run_exit    = 1'b0;
    case (state)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (start) begin
          start_ok    = 1'b1;
          found_key_n = '0;
          if (key_lo > key_hi) begin
            state_n = ST_EXHAUSTED;
          end else begin
            key_n    = key_lo;
            key_hi_n = key_hi;
            state_n  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (cnt_done) begin
          state_n = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (eng_done) begin
          run_exit    = 1'b1;
          found_key_n = key;
          state_n     = ST_FOUND;
        end else if (eng_fail) begin
          run_exit = 1'b1;
          if (next_key[KEY_W] || (next_key[KEY_W-1:0] > key_hi_q)) begin
            state_n = ST_EXHAUSTED;
          end else begin
            key_n   = next_key[KEY_W-1:0];
            state_n = ST_LOAD;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      key       <= '0;
      found_key <= '0;
      key_hi_q  <= '0;
      eng_reset <= 1'b1;
      eng_start <= 1'b0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state     <= state_n;
      key       <= key_n;
      found_key <= found_key_n;
      key_hi_q  <= key_hi_n;
      eng_reset <= (state_n != ST_RUN);
      eng_start <= (state_n == ST_RUN);
      busy      <= (state_n == ST_LOAD) || (state_n == ST_SETTLE) || (state_n == ST_RUN);
      found     <= (state_n == ST_FOUND);
      exhausted <= (state_n == ST_EXHAUSTED);
    end
  end

`ifdef KEY_SEARCH_PROGRESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tried_count <= '0;
    end else if (start_ok) begin
      tried_count <= '0;
    end else if (run_exit) begin
      tried_count <= tried_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: one STRIDE=1 instance and one STRIDE=4 instance,
// each driven by a small behavioural engine model.
module tb_key_search_ctrl;
  import key_search_pkg::*;

  localparam int KW = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance a: STRIDE=1
  logic          start_a, abort_a, eng_done_a, eng_fail_a;
  logic [KW-1:0] key_lo_a, key_hi_a, key_a, found_key_a;
  logic          eng_reset_a, eng_start_a, busy_a, found_a, exhausted_a;
  logic [2:0]    state_a;
  // instance b: STRIDE=4
  logic          start_b, abort_b, eng_done_b, eng_fail_b;
  logic [KW-1:0] key_lo_b, key_hi_b, key_b, found_key_b;
  logic          eng_reset_b, eng_start_b, busy_b, found_b, exhausted_b;
  logic [2:0]    state_b;
`ifdef KEY_SEARCH_PROGRESS_EN
  logic [KW:0]   tried_a, tried_b;
`endif

  key_search_ctrl #(.KEY_W(KW), .STRIDE(1), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key_lo(key_lo_a), .key_hi(key_hi_a),
    .abort(abort_a), .eng_done(eng_done_a), .eng_fail(eng_fail_a),
    .eng_reset(eng_reset_a), .eng_start(eng_start_a), .key(key_a), .busy(busy_a),
    .found(found_a), .exhausted(exhausted_a), .found_key(found_key_a), .state_dbg(state_a)
`ifdef KEY_SEARCH_PROGRESS_EN
    , .tried_count(tried_a)
`endif
  );

  key_search_ctrl #(.KEY_W(KW), .STRIDE(4), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key_lo(key_lo_b), .key_hi(key_hi_b),
    .abort(abort_b), .eng_done(eng_done_b), .eng_fail(eng_fail_b),
    .eng_reset(eng_reset_b), .eng_start(eng_start_b), .key(key_b), .busy(busy_b),
    .found(found_b), .exhausted(exhausted_b), .found_key(found_key_b), .state_dbg(state_b)
`ifdef KEY_SEARCH_PROGRESS_EN
    , .tried_count(tried_b)
`endif
  );

  // Engine model modes: 0 silent, 1 always fail, 2 done on target else fail, 3 fail always + done on target
  int            mode_a;
  logic [KW-1:0] target_a;

  always_comb begin
    eng_done_a = eng_start_a && ((mode_a == 2) || (mode_a == 3)) && (key_a == target_a);
    eng_fail_a = eng_start_a && ((mode_a == 1) || (mode_a == 3) || ((mode_a == 2) && (key_a != target_a)));
    eng_done_b = 1'b0;
    eng_fail_b = eng_start_b;
  end

  // Scoreboard: keys the engine was started on, against the expected sequence
  logic [KW-1:0] exp_q[$];
  logic [KW-1:0] got_q[$];
  logic [KW-1:0] got_b_q[$];

  always @(posedge clk) begin
    if (!reset && eng_start_a) got_q.push_back(key_a);
    if (!reset && eng_start_b) got_b_q.push_back(key_b);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_keys_a(input string tag);
    check({tag, "_nkeys"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_key"}, got_q[i], exp_q[i]);
  endtask

  task automatic pulse_start_a(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
    @(negedge clk);
    key_lo_a = lo;
    key_hi_a = hi;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!(found_a || exhausted_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, (n < 200), 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_eng_reset"}, eng_reset_a, 1);
    check({tag, "_eng_start"}, eng_start_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_found"}, found_a, 0);
    check({tag, "_exhausted"}, exhausted_a, 0);
    check({tag, "_key"}, key_a, 0);
    check({tag, "_found_key"}, found_key_a, 0);
    check({tag, "_state"}, state_a, 0);
`ifdef KEY_SEARCH_PROGRESS_EN
    check({tag, "_tried"}, tried_a, 0);
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start_a = 0; abort_a = 0; key_lo_a = '0; key_hi_a = '0;
    start_b = 0; abort_b = 0; key_lo_b = '0; key_hi_b = '0;
    mode_a = 0; target_a = '0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    check("rst_b_eng_reset", eng_reset_b, 1);
    @(negedge clk);
    reset = 1'b0;

    // Find key 5 in 0..F, with per-key latency check on the first key
    mode_a = 2; target_a = 24'h000005;
    got_q.delete();
    pulse_start_a(24'h000000, 24'h00000F);
    check("t1_load_state", state_a, 1);
    check("t1_load_busy", busy_a, 1);
    check("t1_load_eng_reset", eng_reset_a, 1);
    @(negedge clk);
    check("t1_settle1_eng_start", eng_start_a, 0);
    @(negedge clk);
    check("t1_settle2_eng_start", eng_start_a, 0);
    @(negedge clk);
    check("t1_run_eng_start", eng_start_a, 1);
    check("t1_run_eng_reset", eng_reset_a, 0);
    wait_done_a("t1");
    check("t1_found", found_a, 1);
    check("t1_exhausted", exhausted_a, 0);
    check("t1_found_key", found_key_a, 24'h000005);
    check("t1_busy", busy_a, 0);
    check("t1_eng_reset", eng_reset_a, 1);
    check("t1_eng_start", eng_start_a, 0);
`ifdef KEY_SEARCH_PROGRESS_EN
    check("t1_tried", tried_a, 6);
`endif
    exp_q.delete();
    for (int k = 0; k <= 5; k++) exp_q.push_back(KW'(k));
    check_keys_a("t1");
    // abort is ignored in FOUND
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t1_abort_ignored_found", found_a, 1);
    check("t1_abort_ignored_state", state_a, 4);

    // Exhaust 0x10..0x13; a start pulse while busy must be ignored
    mode_a = 1;
    got_q.delete();
    pulse_start_a(24'h000010, 24'h000013);
    key_lo_a = 24'h000000;
    key_hi_a = 24'h00000F;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    wait_done_a("t2");
    check("t2_exhausted", exhausted_a, 1);
    check("t2_found", found_a, 0);
    check("t2_key", key_a, 24'h000013);
`ifdef KEY_SEARCH_PROGRESS_EN
    check("t2_tried", tried_a, 4);
`endif
    exp_q.delete();
    for (int k = 16; k <= 19; k++) exp_q.push_back(KW'(k));
    check_keys_a("t2");

    // done and fail together on key 2: done wins
    mode_a = 3; target_a = 24'h000002;
    got_q.delete();
    pulse_start_a(24'h000000, 24'h00000F);
    wait_done_a("t3");
    check("t3_found", found_a, 1);
    check("t3_found_key", found_key_a, 24'h000002);
    exp_q.delete();
    for (int k = 0; k <= 2; k++) exp_q.push_back(KW'(k));
    check_keys_a("t3");

    // abort during SETTLE on key 3
    mode_a = 1;
    pulse_start_a(24'h000000, 24'h00000F);
    n = 0;
    while (!((key_a == 24'h000003) && (state_a == 3'd2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_settle_k3", (n < 100), 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t4_state", state_a, 0);
    check("t4_busy", busy_a, 0);
    check("t4_eng_reset", eng_reset_a, 1);
    check("t4_eng_start", eng_start_a, 0);
    check("t4_found", found_a, 0);
    check("t4_exhausted", exhausted_a, 0);
    // restart from IDLE with start and abort together: start wins
    mode_a = 2; target_a = 24'h000001;
    got_q.delete();
    @(negedge clk);
    key_lo_a = 24'h000000;
    key_hi_a = 24'h00000F;
    start_a  = 1'b1;
    abort_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    abort_a  = 1'b0;
    check("t4_restart_busy", busy_a, 1);
    check("t4_restart_state", state_a, 1);
    wait_done_a("t4");
    check("t4_found_key", found_key_a, 24'h000001);
    exp_q.delete();
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'h000001);
    check_keys_a("t4");

    // reset mid-RUN, then an empty range
    mode_a = 0;
    pulse_start_a(24'h000000, 24'h00000F);
    n = 0;
    while (!eng_start_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_run", eng_start_a, 1);
    #2 reset = 1'b1;
    #1 check_reset_a("t5_rst");
    @(negedge clk);
    reset = 1'b0;
    pulse_start_a(24'h000020, 24'h000010);
    check("t5_exhausted", exhausted_a, 1);
    check("t5_busy", busy_a, 0);
    check("t5_key", key_a, 24'h000000);
    check("t5_eng_reset", eng_reset_a, 1);

    // STRIDE=4 near the top of the key space: no wrap to zero
    got_b_q.delete();
    @(negedge clk);
    key_lo_b = 24'hFFFFF8;
    key_hi_b = 24'hFFFFFF;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    n = 0;
    while (!exhausted_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout", (n < 100), 1);
    check("t6_exhausted", exhausted_b, 1);
    check("t6_key", key_b, 24'hFFFFFC);
    check("t6_nkeys", got_b_q.size(), 2);
    if (got_b_q.size() >= 2) begin
      check("t6_key0", got_b_q[0], 24'hFFFFF8);
      check("t6_key1", got_b_q[1], 24'hFFFFFC);
    end
`ifdef KEY_SEARCH_PROGRESS_EN
    check("t6_tried", tried_b, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
